// File: rtl/data_memory_responder_pkg.sv
// Shared types for the data memory responder: FSM states, operation codes, default sizes.
package mem_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_ILLEGAL = 2'd2
  } op_t;

  // Only meaningful when at least one of rd/wr is set.
  function automatic op_t decode_op(input logic rd, input logic wr);
    if (rd && wr)
      return OP_ILLEGAL;
    else if (rd)
      return OP_READ;
    else
      return OP_WRITE;
  endfunction

endpackage

// File: rtl/data_memory_responder_ram.sv
// Single-port synchronous RAM: write on we, registered read on re; only the read register resets.
module sp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rdata <= '0;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-stage data memory: accepts one request, waits WAIT_STATES cycles, then pulses ready/err.
// Requester holds cs until ready; dropping cs during the wait aborts the transaction.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            state;
  logic [3:0]        cnt;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oor_q;
  logic              rd_zero_q;

  logic              req_any;
  logic              accept;
  logic              finish;
  op_t               c_op;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_oor;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;

  assign req_any = cs && (mem_read || mem_write);
  assign accept  = (state == IDLE) && req_any;

  // With zero wait states the commit happens on the acceptance edge, so the live request is used.
  always_comb begin
    c_op    = op_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_oor   = oor_q;
    if (state == IDLE) begin
      c_op    = decode_op(mem_read, mem_write);
      c_addr  = addr[ADDR_W-1:0];
      c_wdata = wdata;
      c_oor   = |addr[31:ADDR_W];
    end
  end

  assign finish = (accept && (WS == 4'd0)) ||
                  ((state == WAIT) && cs && (cnt == 4'd1));

  assign ram_we = rst_n && finish && (c_op == OP_WRITE) && !c_oor;
  assign ram_re = rst_n && finish && (c_op == OP_READ) && !c_oor;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      oor_q     <= 1'b0;
      rd_zero_q <= 1'b0;
      ready     <= 1'b0;
      err       <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= c_op;
            addr_q  <= c_addr;
            wdata_q <= c_wdata;
            oor_q   <= c_oor;
            cnt     <= WS;
            state   <= (WS == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (!cs)
            state <= IDLE;
          else if (cnt == 4'd1)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (finish) begin
        ready <= 1'b1;
        err   <= c_oor || (c_op == OP_ILLEGAL);
        if (c_op == OP_READ)
          rd_zero_q <= c_oor;
      end
    end
  end

  sp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .re   (ram_re),
    .addr (c_addr),
    .wdata(c_wdata),
    .rdata(ram_q)
  );

  // Out-of-range reads return zero; the flag persists so rdata holds its last value.
  assign rdata = rd_zero_q ? '0 : ram_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Four responders with WAIT_STATES 0..3 sharing request inputs; each has its own chip select.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cs = 4'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [15:0] wdata = 16'd0;
  logic [15:0] rdata_v [4];
  logic [3:0]  ready_v;
  logic [3:0]  err_v;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DATA_W(16), .ADDR_W(12), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .cs(cs[0]), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]));
  data_memory_responder #(.DATA_W(16), .ADDR_W(12), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .cs(cs[1]), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]));
  data_memory_responder #(.DATA_W(16), .ADDR_W(12), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .cs(cs[2]), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_v[2]), .ready(ready_v[2]), .err(err_v[2]));
  data_memory_responder #(.DATA_W(16), .ADDR_W(12), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .cs(cs[3]), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_v[3]), .ready(ready_v[3]), .err(err_v[3]));

  // Drives one request on responder idx and holds it until ready. lat counts edges after
  // the acceptance edge before ready is seen (-1 on timeout). pulse_ok: ready/err low next cycle.
  task automatic txn(input int idx, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [15:0] wd, input logic chg, input logic [31:0] a2,
                     output int lat, output logic [15:0] rdo, output logic eo,
                     output logic pulse_ok);
    @(negedge clk);
    addr = a; wdata = wd; mem_read = rd; mem_write = wr; cs[idx] = 1'b1;
    @(posedge clk); #1;
    if (chg) addr = a2;
    lat = -1; rdo = 16'hxxxx; eo = 1'bx;
    for (int k = 0; k < 40; k++) begin
      if (ready_v[idx]) begin
        lat = k; rdo = rdata_v[idx]; eo = err_v[idx];
        break;
      end
      @(posedge clk); #1;
    end
    cs[idx] = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    pulse_ok = !ready_v[idx] && !err_v[idx];
  endtask

  task automatic test_reset();
    int lat; logic [15:0] d; logic e, p;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    txn(1, 0, 1, 32'h20, 16'hDEAD, 0, 0, lat, d, e, p);
    txn(1, 0, 1, 32'h21, 16'h5A5A, 0, 0, lat, d, e, p);
    txn(1, 1, 0, 32'h21, 16'h0, 0, 0, lat, d, e, p);
    total++; if (d !== 16'h5A5A) begin bad++; $display("FAIL reset_pre_read got=%h exp=5a5a", d); end
    @(negedge clk);
    rst_n = 1'b0; cs[1] = 1'b1; mem_write = 1'b1; addr = 32'h20; wdata = 16'h1111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (ready_v !== 4'b0 || err_v !== 4'b0) begin
        bad++; $display("FAIL reset_ready_err cyc=%0d ready=%b err=%b exp=0", c, ready_v, err_v);
      end
    end
    total++; if (rdata_v[1] !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_v[1]); end
    @(negedge clk); rst_n = 1'b1; cs[1] = 1'b0; mem_write = 1'b0;
    txn(1, 1, 0, 32'h20, 16'h0, 0, 0, lat, d, e, p);
    total++; if (d !== 16'hDEAD || e !== 1'b0) begin bad++; $display("FAIL reset_no_commit got=%h err=%b exp=dead/0", d, e); end
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] d; logic e, p;
    txn(1, 0, 1, 32'd5, 16'h1234, 0, 0, lat, d, e, p);
    total++; if (lat != 1 || e !== 1'b0 || !p) begin bad++; $display("FAIL wr_ws1 lat=%0d err=%b pulse=%b exp=1/0/1", lat, e, p); end
    txn(1, 1, 0, 32'd5, 16'h0, 0, 0, lat, d, e, p);
    total++; if (lat != 1 || d !== 16'h1234 || e !== 1'b0 || !p) begin
      bad++; $display("FAIL rd_ws1 lat=%0d data=%h err=%b pulse=%b exp=1/1234/0/1", lat, d, e, p);
    end
  endtask

  task automatic test_back_to_back();
    int lat, seen; logic [15:0] d; logic e, p;
    int got_cyc [3]; logic [15:0] got_dat [3];
    for (int i = 0; i < 3; i++) begin
      txn(0, 0, 1, i, 16'h00A0 + 16'(i), 0, 0, lat, d, e, p);
      total++; if (lat != 0 || e !== 1'b0) begin bad++; $display("FAIL ws0_wr%0d lat=%0d err=%b exp=0/0", i, lat, e); end
    end
    seen = 0;
    @(negedge clk); cs[0] = 1'b1; mem_read = 1'b1; addr = 32'd0;
    for (int c = 0; c < 12 && seen < 3; c++) begin
      @(posedge clk); #1;
      if (ready_v[0]) begin
        got_cyc[seen] = c; got_dat[seen] = rdata_v[0]; seen++;
        if (seen < 3) addr = 32'(seen);
      end
    end
    cs[0] = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    total++;
    if (seen != 3) begin
      bad++; $display("FAIL b2b_count got=%0d exp=3", seen);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_cyc[i] != 2 * i || got_dat[i] !== 16'h00A0 + 16'(i)) begin
          bad++; $display("FAIL b2b_%0d cyc=%0d data=%h exp=%0d/%h", i, got_cyc[i], got_dat[i], 2 * i, 16'h00A0 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_illegal_oor();
    int lat; logic [15:0] d; logic e, p;
    txn(1, 0, 1, 32'd7, 16'h0707, 0, 0, lat, d, e, p);
    txn(1, 0, 1, 32'd0, 16'h00A0, 0, 0, lat, d, e, p);
    txn(1, 1, 0, 32'd7, 16'h0, 0, 0, lat, d, e, p);
    txn(1, 1, 1, 32'd7, 16'h1111, 0, 0, lat, d, e, p);
    total++; if (lat != 1 || e !== 1'b1 || d !== 16'h0707) begin
      bad++; $display("FAIL illegal lat=%0d err=%b data=%h exp=1/1/0707", lat, e, d);
    end
    txn(1, 1, 0, 32'd7, 16'h0, 0, 0, lat, d, e, p);
    total++; if (d !== 16'h0707 || e !== 1'b0) begin bad++; $display("FAIL illegal_mem got=%h err=%b exp=0707/0", d, e); end
    txn(1, 1, 0, 32'h0001_0000, 16'h0, 0, 0, lat, d, e, p);
    total++; if (lat != 1 || e !== 1'b1 || d !== 16'h0) begin
      bad++; $display("FAIL oor_read lat=%0d err=%b data=%h exp=1/1/0", lat, e, d);
    end
    txn(1, 0, 1, 32'h0000_1000, 16'hFFFF, 0, 0, lat, d, e, p);
    total++; if (lat != 1 || e !== 1'b1 || !p) begin bad++; $display("FAIL oor_write lat=%0d err=%b pulse=%b exp=1/1/1", lat, e, p); end
    txn(1, 1, 0, 32'd0, 16'h0, 0, 0, lat, d, e, p);
    total++; if (d !== 16'h00A0 || e !== 1'b0) begin bad++; $display("FAIL oor_write_dropped got=%h err=%b exp=00a0/0", d, e); end
  endtask

  task automatic test_abort();
    int lat, seen; logic [15:0] d; logic e, p;
    txn(3, 0, 1, 32'd9, 16'h0909, 0, 0, lat, d, e, p);
    total++; if (lat != 3 || e !== 1'b0) begin bad++; $display("FAIL ws3_wr lat=%0d err=%b exp=3/0", lat, e); end
    @(negedge clk); cs[3] = 1'b1; mem_write = 1'b1; addr = 32'd9; wdata = 16'hBEEF;
    @(negedge clk); cs[3] = 1'b0; mem_write = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ready_v[3] || err_v[3]) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_ready got=%0d pulses exp=0", seen); end
    txn(3, 1, 0, 32'd9, 16'h0, 0, 0, lat, d, e, p);
    total++; if (d !== 16'h0909 || lat != 3) begin bad++; $display("FAIL abort_mem got=%h lat=%0d exp=0909/3", d, lat); end
  endtask

  task automatic test_mid_change();
    int lat; logic [15:0] d; logic e, p;
    txn(2, 0, 1, 32'd3, 16'h0303, 0, 0, lat, d, e, p);
    txn(2, 0, 1, 32'd4, 16'h0404, 0, 0, lat, d, e, p);
    txn(2, 0, 1, 32'd3, 16'h5555, 1, 32'd4, lat, d, e, p);
    total++; if (lat != 2 || e !== 1'b0) begin bad++; $display("FAIL mid_wr lat=%0d err=%b exp=2/0", lat, e); end
    txn(2, 1, 0, 32'd3, 16'h0, 0, 0, lat, d, e, p);
    total++; if (d !== 16'h5555) begin bad++; $display("FAIL mid_addr3 got=%h exp=5555", d); end
    txn(2, 1, 0, 32'd4, 16'h0, 0, 0, lat, d, e, p);
    total++; if (d !== 16'h0404) begin bad++; $display("FAIL mid_addr4 got=%h exp=0404", d); end
  endtask

  // Reference model: a 16-word array plus the last value a read delivered.
  task automatic test_random();
    int lat, kind; logic [15:0] d, wd, rd_m; logic e, p, exp_e, rd, wr;
    logic [15:0] mm [16];
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      mm[i] = 16'($urandom);
      txn(2, 0, 1, i, mm[i], 0, 0, lat, d, e, p);
    end
    txn(2, 1, 0, 32'd0, 16'h0, 0, 0, lat, d, e, p);
    rd_m = mm[0];
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15));
      wd = 16'($urandom);
      rd = (kind >= 4 && kind <= 7) || kind == 8;
      wr = kind <= 3 || kind == 8;
      exp_e = (kind >= 8);
      if (kind == 9) begin
        rd = $urandom_range(0, 1) == 1;
        wr = !rd;
        a = a | (32'd1 << $urandom_range(12, 31));
      end
      txn(2, rd, wr, a, wd, 0, 0, lat, d, e, p);
      if (kind <= 3) mm[a[3:0]] = wd;
      else if (kind <= 7) rd_m = mm[a[3:0]];
      else if (kind == 9 && rd) rd_m = 16'h0;
      total++;
      if (lat != 2 || e !== exp_e || d !== rd_m || !p) begin
        bad++; $display("FAIL rand_%0d kind=%0d addr=%h lat=%0d err=%b data=%h pulse=%b exp=2/%b/%h/1",
                        n, kind, a, lat, e, d, p, exp_e, rd_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_illegal_oor();
    test_abort();
    test_mid_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
